store_write_buffer: RTL and testbench

//  Posted-write FIFO between the core's data write bus and a slower data memory with a valid/ready write port.

---
 rtl/store_write_buffer_pkg.sv | 27 ++
 rtl/store_write_buffer_fwd.sv | 37 +++
 rtl/store_write_buffer.sv | 138 +++++++++++++
 tb/tb_store_write_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared types for the store write buffer. Word addresses are held zero-extended
// to WORD_W bits, so any ADDR_W up to 64 fits one entry layout.
package store_write_buffer_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int WORD_W = 62;

  typedef logic [STRB_W-1:0] ByteStrb;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [DATA_W-1:0] data;
    ByteStrb           strb;
  } StoreEntry;

  // Expands byte enables into a 32-bit bit mask.
  function automatic logic [DATA_W-1:0] lane_mask(input ByteStrb strb);
    logic [DATA_W-1:0] mask;
    mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/store_write_buffer_fwd.sv
// Store-to-load forwarding merge for the store write buffer; built only when
// STORE_BUF_FWD_EN is defined (the default build has no forwarding path).
`ifdef STORE_BUF_FWD_EN
module store_fwd_merge
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  StoreEntry         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic              ld_valid,
  input  logic [WORD_W-1:0] ld_word,
  output logic              hit,
  output logic [DATA_W-1:0] data,
  output ByteStrb           strb
);

  // Entries arrive oldest first, so a later match overwrites its lanes and the
  // youngest store owning each byte wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    strb = '0;
    if (ld_valid) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (valid[k] && (entries[k].word == ld_word)) begin
          hit  = 1'b1;
          strb = strb | entries[k].strb;
          data = (data & ~lane_mask(entries[k].strb)) |
                 (entries[k].data & lane_mask(entries[k].strb));
        end
      end
    end
  end

endmodule
`endif

// File: rtl/store_write_buffer.sv
// Posted-write FIFO between core stores and data memory, with load snooping.
// Define STORE_BUF_FWD_EN to forward buffered bytes instead of only flagging a stall.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_strb,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  output logic [3:0]               ld_strb,
  output logic                     mem_wvalid,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_wready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  StoreEntry         entries [DEPTH];
  StoreEntry         new_entry;
  logic [DEPTH-1:0]  valid;
  logic [WORD_W-1:0] ld_word;
  logic              full;
  logic              push;
  logic              pop;
  logic              unused_addr_bits;

  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign wr_idx = wr_ptr[IDX_W-1:0];

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);
  assign empty    = (wr_ptr == rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign st_ready = !full;

  // A zero-strobe store completes its handshake but never occupies an entry.
  assign push = st_valid && !full && (|st_strb);
  assign pop  = !empty && mem_wready;

  assign new_entry.word = WORD_W'(st_addr[ADDR_W-1:2]);
  assign new_entry.data = st_data;
  assign new_entry.strb = st_strb;

  assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (push) begin
        entries[wr_idx] <= new_entry;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign mem_wvalid = !empty;
  assign mem_waddr  = {entries[rd_idx].word[ADDR_W-3:0], 2'b00};
  assign mem_wdata  = entries[rd_idx].data;
  assign mem_wstrb  = entries[rd_idx].strb;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = PTR_W'(IDX_W'(IDX_W'(i) - rd_idx)) < count;
    end
  end

  assign ld_word = WORD_W'(ld_addr[ADDR_W-1:2]);

`ifdef STORE_BUF_FWD_EN
  StoreEntry        aged       [DEPTH];
  logic [DEPTH-1:0] aged_valid;

  always_comb begin
    aged_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      aged[k]       = entries[IDX_W'(rd_idx + IDX_W'(k))];
      aged_valid[k] = PTR_W'(k) < count;
    end
  end

  store_fwd_merge #(
    .DEPTH (DEPTH)
  ) u_fwd_merge (
    .entries  (aged),
    .valid    (aged_valid),
    .ld_valid (ld_valid),
    .ld_word  (ld_word),
    .hit      (ld_hit),
    .data     (ld_data),
    .strb     (ld_strb)
  );
`else
  // Without forwarding a hit is purely a stall request to the core.
  always_comb begin
    ld_hit = 1'b0;
    if (ld_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && (entries[i].word == ld_word)) begin
          ld_hit = 1'b1;
        end
      end
    end
  end

  assign ld_data = '0;
  assign ld_strb = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed table, hand sequences and
// randomized traffic checked against a queue-based reference model.
module tb_store_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   st_valid;
  logic [ADDR_W-1:0]      st_addr;
  logic [31:0]            st_data;
  logic [3:0]             st_strb;
  logic                   st_ready;
  logic                   ld_valid;
  logic [ADDR_W-1:0]      ld_addr;
  logic                   ld_hit;
  logic [31:0]            ld_data;
  logic [3:0]             ld_strb;
  logic                   mem_wvalid;
  logic [ADDR_W-1:0]      mem_waddr;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_wstrb;
  logic                   mem_wready;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;

  always #5 clk = ~clk;

  store_write_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_strb    (st_strb),
    .st_ready   (st_ready),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_hit     (ld_hit),
    .ld_data    (ld_data),
    .ld_strb    (ld_strb),
    .mem_wvalid (mem_wvalid),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_wready (mem_wready),
    .count      (count),
    .empty      (empty)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] data;
    logic [3:0]  strb;
  } model_entry_t;

  typedef struct {
    logic        sv;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        wr;
    logic [2:0]  exp_count;
    logic        exp_ready;
    logic        exp_wvalid;
    logic [31:0] exp_head;
  } vec_t;

  model_entry_t model_q[$];
  vec_t         table_v[13];
  int           vectors     = 0;
  int           miscompares = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                input logic [3:0] ss, input logic mw, input logic lv,
                                input logic [31:0] la);
    st_valid   = sv;
    st_addr    = sa;
    st_data    = sd;
    st_strb    = ss;
    mem_wready = mw;
    ld_valid   = lv;
    ld_addr    = la;
    #1;
  endtask

  // Reference model: a store is taken whenever fewer than DEPTH stores are pending
  // (judged before this cycle's pop), the oldest leaves when memory is ready.
  function automatic void model_step();
    bit           accept;
    bit           do_pop;
    model_entry_t e;
    accept = st_valid && (model_q.size() < DEPTH);
    do_pop = (model_q.size() > 0) && mem_wready;
    e.word = st_addr >> 2;
    e.data = st_data;
    e.strb = st_strb;
    if (do_pop) void'(model_q.pop_front());
    if (accept && (st_strb != 4'b0000)) model_q.push_back(e);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag);
    logic        hit;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] mask;
    hit = 1'b0;
    d   = '0;
    s   = '0;
    if (ld_valid) begin
      foreach (model_q[i]) begin
        if (model_q[i].word == (ld_addr >> 2)) begin
          hit = 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (model_q[i].strb[b]) begin
              s[b]        = 1'b1;
              d[8*b +: 8] = model_q[i].data[8*b +: 8];
            end
          end
        end
      end
    end
    check({tag, " count"}, 64'(count), 64'(model_q.size()));
    check({tag, " empty"}, 64'(empty), 64'(model_q.size() == 0));
    check({tag, " st_ready"}, 64'(st_ready), 64'(model_q.size() < DEPTH));
    check({tag, " mem_wvalid"}, 64'(mem_wvalid), 64'(model_q.size() != 0));
    if (model_q.size() > 0) begin
      check({tag, " mem_waddr"}, 64'(mem_waddr), 64'({model_q[0].word[29:0], 2'b00}));
      check({tag, " mem_wdata"}, 64'(mem_wdata), 64'(model_q[0].data));
      check({tag, " mem_wstrb"}, 64'(mem_wstrb), 64'(model_q[0].strb));
    end
    check({tag, " ld_hit"}, 64'(ld_hit), 64'(hit));
`ifdef STORE_BUF_FWD_EN
    mask = '0;
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{s[b]}};
    check({tag, " ld_strb"}, 64'(ld_strb), 64'(s));
    check({tag, " ld_data"}, 64'(ld_data & mask), 64'(d));
`else
    mask = '0;
    check({tag, " ld_strb"}, 64'(ld_strb), 64'(mask[3:0]));
    check({tag, " ld_data"}, 64'(ld_data), 64'(mask));
`endif
  endtask

  initial begin
    table_v[0]  = '{1'b1, 32'h1000, 32'h0000_00A0, 4'hF, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0000_00A0};
    table_v[1]  = '{1'b1, 32'h1004, 32'h0000_00B0, 4'hF, 1'b0, 3'd2, 1'b1, 1'b1, 32'h0000_00A0};
    table_v[2]  = '{1'b1, 32'h1008, 32'h0000_00C0, 4'hF, 1'b0, 3'd3, 1'b1, 1'b1, 32'h0000_00A0};
    table_v[3]  = '{1'b1, 32'h100C, 32'h0000_00D0, 4'hF, 1'b0, 3'd4, 1'b0, 1'b1, 32'h0000_00A0};
    table_v[4]  = '{1'b1, 32'h1010, 32'h0000_00E0, 4'hF, 1'b0, 3'd4, 1'b0, 1'b1, 32'h0000_00A0};
    table_v[5]  = '{1'b1, 32'h1010, 32'h0000_00E0, 4'hF, 1'b1, 3'd3, 1'b1, 1'b1, 32'h0000_00B0};
    table_v[6]  = '{1'b0, 32'h0000, 32'h0000_0000, 4'h0, 1'b1, 3'd2, 1'b1, 1'b1, 32'h0000_00C0};
    table_v[7]  = '{1'b1, 32'h1010, 32'h0000_00E0, 4'hF, 1'b1, 3'd2, 1'b1, 1'b1, 32'h0000_00D0};
    table_v[8]  = '{1'b0, 32'h0000, 32'h0000_0000, 4'h0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h0000_00E0};
    table_v[9]  = '{1'b1, 32'h1014, 32'h0000_00F0, 4'h0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h0000_00E0};
    table_v[10] = '{1'b0, 32'h0000, 32'h0000_0000, 4'h0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0000_0000};
    table_v[11] = '{1'b1, 32'h1100, 32'h0000_0123, 4'h5, 1'b1, 3'd1, 1'b1, 1'b1, 32'h0000_0123};
    table_v[12] = '{1'b0, 32'h0000, 32'h0000_0000, 4'h0, 1'b1, 3'd0, 1'b1, 1'b0, 32'h0000_0000};

    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset count", 64'(count), 64'd0);
    check("reset empty", 64'(empty), 64'd1);
    check("reset st_ready", 64'(st_ready), 64'd1);
    check("reset mem_wvalid", 64'(mem_wvalid), 64'd0);
    check("reset mem_waddr", 64'(mem_waddr), 64'd0);
    check("reset mem_wdata", 64'(mem_wdata), 64'd0);
    check("reset mem_wstrb", 64'(mem_wstrb), 64'd0);
    check("reset ld_hit", 64'(ld_hit), 64'd0);
    check("reset ld_data", 64'(ld_data), 64'd0);
    check("reset ld_strb", 64'(ld_strb), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] directed table: fill, full refusal, push+pop, zero strobe");
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(table_v[i].sv, table_v[i].addr, table_v[i].data, table_v[i].strb,
                     table_v[i].wr, 1'b0, 32'h0);
      tick();
      check($sformatf("table[%0d] count", i), 64'(count), 64'(table_v[i].exp_count));
      check($sformatf("table[%0d] st_ready", i), 64'(st_ready), 64'(table_v[i].exp_ready));
      check($sformatf("table[%0d] mem_wvalid", i), 64'(mem_wvalid), 64'(table_v[i].exp_wvalid));
      if (table_v[i].exp_wvalid) begin
        check($sformatf("table[%0d] head data", i), 64'(mem_wdata), 64'(table_v[i].exp_head));
      end
    end

    $display("[TB] backpressure hold");
    apply_stimulus(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
      check("stall mem_wvalid", 64'(mem_wvalid), 64'd1);
      check("stall mem_waddr", 64'(mem_waddr), 64'h100);
      check("stall mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      check("stall mem_wstrb", 64'(mem_wstrb), 64'hF);
      tick();
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    check("stall release wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    tick();
    check("stall popped count", 64'(count), 64'd0);

    $display("[TB] load snoop and forwarding");
    apply_stimulus(1'b1, 32'h200, 32'h1122_3344, 4'b0011, 1'b0, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b1, 32'h200, 32'hAABB_CCDD, 4'b0110, 1'b0, 1'b0, 32'h0);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h202);
    check("fwd ld_hit", 64'(ld_hit), 64'd1);
`ifdef STORE_BUF_FWD_EN
    check("fwd ld_strb", 64'(ld_strb), 64'b0111);
    check("fwd ld_data", 64'(ld_data[23:0]), 64'hBBCC44);
`else
    check("nofwd ld_strb", 64'(ld_strb), 64'd0);
    check("nofwd ld_data", 64'(ld_data), 64'd0);
`endif
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h204);
    check("other word ld_hit", 64'(ld_hit), 64'd0);
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h202);
    check("idle load ld_hit", 64'(ld_hit), 64'd0);
    check("idle load ld_strb", 64'(ld_strb), 64'd0);
    apply_stimulus(1'b1, 32'h200, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'h0);
    tick();
    check("zero strobe count", 64'(count), 64'd2);
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h202);
    check_output("drain0");
    tick();
    check_output("drain1");
    tick();
    check_output("drain2");
    check("hit clears after drain", 64'(ld_hit), 64'd0);

    apply_stimulus(1'b1, 32'h300, 32'h5555_AAAA, 4'hF, 1'b0, 1'b1, 32'h300);
    check("same-cycle push not snooped", 64'(ld_hit), 64'd0);
    tick();
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h300);
    check("push visible next cycle", 64'(ld_hit), 64'd1);
    tick();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] sa;
      logic [31:0] la;
      logic [3:0]  ss;
      sa = 32'h400 + 32'($urandom_range(0, 5) << 2) + 32'($urandom_range(0, 3));
      la = 32'h400 + 32'($urandom_range(0, 5) << 2) + 32'($urandom_range(0, 3));
      ss = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      apply_stimulus(1'($urandom_range(0, 2) != 0), sa, $urandom, ss,
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0), la);
      check_output($sformatf("rand[%0d]", i));
      tick();
    end

    $display("[TB] async reset mid-drain");
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h500 + 32'(i * 4), 32'h7000 + 32'(i), 4'hF, 1'b0, 1'b0, 32'h0);
      tick();
    end
    check("pre-reset count", 64'(count), 64'd3);
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h500);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset count", 64'(count), 64'd0);
    check("async reset mem_wvalid", 64'(mem_wvalid), 64'd0);
    check("async reset st_ready", 64'(st_ready), 64'd1);
    check("async reset ld_hit", 64'(ld_hit), 64'd0);
    model_q.delete();
    @(posedge clk);
    #1;
    check("held reset count", 64'(count), 64'd0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h500);
    check_output("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
